// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START, STOP, WRITE_BYTE and READ_BYTE primitives on open-drain SCL/SDA.
// Optional SCL clock stretching is compiled in with the I2C_CLK_STRETCH_EN macro.
//
//   state  | meaning
//   IDLE   | waiting for enable_i, pads hold their end-of-command levels
//   START  | (repeated) start condition, 4 quarters
//   STOP   | stop condition, 4 quarters, leaves bus released
//   WR_BIT | shifting out 8 data bits MSB first
//   WR_ACK | SDA released, slave ACK sampled
//   RD_BIT | SDA released, 8 bits shifted in
//   RD_ACK | master drives ACK low
module i2c_master_ctrl #(
    parameter logic [7:0] ClkDiv = 8'd67
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] instr_i,
    input  logic       enable_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o,
    output logic       ack_o,
    output logic       complete_o,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    input  logic       sda_i,
    input  logic       scl_i
);

    typedef enum logic [2:0] {
        IDLE, START, STOP, WR_BIT, WR_ACK, RD_BIT, RD_ACK
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] qcnt_q;
    logic [1:0] quarter_q;
    logic [2:0] bit_q;
    logic [7:0] shreg_q;
    logic       sda_s1_q, sda_s2_q;
    logic       idle_scl_q, idle_sda_q;
    logic       complete_q;
    logic       stall, q_end, bit_end, sample, cmd_done;

`ifdef I2C_CLK_STRETCH_EN
    logic scl_s1_q, scl_s2_q, stretch_qtr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
        end
    end

    // Quarters in which SCL has just been released and a slave may hold it low
    always_comb begin
        stretch_qtr = 1'b0;
        case (state_q)
            START, STOP:                    stretch_qtr = (quarter_q == 2'd1);
            WR_BIT, WR_ACK, RD_BIT, RD_ACK: stretch_qtr = (quarter_q == 2'd2);
            default:                        stretch_qtr = 1'b0;
        endcase
    end

    assign stall = stretch_qtr && (qcnt_q == 8'd0) && !scl_s2_q;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    assign q_end   = !stall && (qcnt_q == ClkDiv - 8'd1);
    assign bit_end = q_end && (quarter_q == 2'd3);
    assign sample  = q_end && (quarter_q == 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    case (instr_i)
                        2'd0:    state_d = START;
                        2'd1:    state_d = STOP;
                        2'd2:    state_d = RD_BIT;
                        default: state_d = WR_BIT;
                    endcase
                end
            end
            START, STOP, WR_ACK, RD_ACK: if (bit_end) state_d = IDLE;
            WR_BIT: if (bit_end && bit_q == 3'd7) state_d = WR_ACK;
            RD_BIT: if (bit_end && bit_q == 3'd7) state_d = RD_ACK;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_done = (state_q != IDLE) && (state_d == IDLE);

    always_comb begin
        scl_oe_o = idle_scl_q;
        sda_oe_o = idle_sda_q;
        case (state_q)
            START: begin
                case (quarter_q)
                    2'd0:    begin scl_oe_o = 1'b1; sda_oe_o = 1'b0; end
                    2'd1:    begin scl_oe_o = 1'b0; sda_oe_o = 1'b0; end
                    2'd2:    begin scl_oe_o = 1'b0; sda_oe_o = 1'b1; end
                    default: begin scl_oe_o = 1'b1; sda_oe_o = 1'b1; end
                endcase
            end
            STOP: begin
                case (quarter_q)
                    2'd0:    begin scl_oe_o = 1'b1; sda_oe_o = 1'b1; end
                    2'd1:    begin scl_oe_o = 1'b0; sda_oe_o = 1'b1; end
                    default: begin scl_oe_o = 1'b0; sda_oe_o = 1'b0; end
                endcase
            end
            WR_BIT: begin
                scl_oe_o = !quarter_q[1];
                sda_oe_o = !shreg_q[7];
            end
            WR_ACK, RD_BIT: begin
                scl_oe_o = !quarter_q[1];
                sda_oe_o = 1'b0;
            end
            RD_ACK: begin
                scl_oe_o = !quarter_q[1];
                sda_oe_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            qcnt_q     <= 8'd0;
            quarter_q  <= 2'd0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'd0;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            idle_scl_q <= 1'b0;
            idle_sda_q <= 1'b0;
            complete_q <= 1'b1;
            byte_o     <= 8'd0;
            ack_o      <= 1'b0;
        end else begin
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            if (state_q == IDLE) begin
                qcnt_q    <= 8'd0;
                quarter_q <= 2'd0;
                bit_q     <= 3'd0;
                if (enable_i) begin
                    shreg_q    <= byte_i;
                    complete_q <= 1'b0;
                end
            end else begin
                if (!stall) begin
                    if (q_end) begin
                        qcnt_q    <= 8'd0;
                        quarter_q <= quarter_q + 2'd1;
                        if (bit_end) bit_q <= bit_q + 3'd1;
                    end else begin
                        qcnt_q <= qcnt_q + 8'd1;
                    end
                end
                if (state_q == WR_BIT && bit_end) shreg_q <= {shreg_q[6:0], 1'b0};
                if (state_q == RD_BIT && sample)  shreg_q <= {shreg_q[6:0], sda_s2_q};
                if (state_q == WR_ACK && sample)  ack_o   <= !sda_s2_q;
                if (cmd_done) begin
                    complete_q <= 1'b1;
                    // SCL stays low after data bits so the next bit/STOP starts cleanly
                    idle_scl_q <= (state_q != STOP);
                    idle_sda_q <= sda_oe_o;
                    if (state_q == RD_ACK) begin
                        byte_o <= shreg_q;
                        ack_o  <= 1'b0;
                    end
                end
            end
        end
    end

    assign complete_o = complete_q;

endmodule
